// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the bit-serial ALU controller and its 1-bit slice.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'b000,
        OP_OR     = 3'b001,
        OP_NAND   = 3'b010,
        OP_XOR    = 3'b011,
        OP_ADD    = 3'b100,
        OP_SUB    = 3'b101,
        OP_NOR    = 3'b110,
        OP_PASS_A = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // SUB reuses the adder: operand B is inverted and carry-in seeded with 1 by the controller.
    function automatic op_e slice_op_of(op_e op);
        return (op == OP_SUB) ? OP_ADD : op;
    endfunction

    function automatic logic is_arith(op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_slice_1_bit.sv
// Combinational 1-bit ALU slice; carry out is only meaningful for ADD/SUB.
module alu_slice_1_bit
    import alu_pkg::*;
(
    input  logic       slice_a,
    input  logic       slice_b,
    input  logic       slice_cin,
    input  logic [2:0] slice_op,
    output logic       slice_out,
    output logic       slice_cout
);

    always_comb begin
        slice_out  = 1'b0;
        slice_cout = 1'b0;
        case (slice_op)
            OP_AND:  slice_out = slice_a & slice_b;
            OP_OR:   slice_out = slice_a | slice_b;
            OP_NAND: slice_out = ~(slice_a & slice_b);
            OP_XOR:  slice_out = slice_a ^ slice_b;
            OP_ADD, OP_SUB: begin
                slice_out  = slice_a ^ slice_b ^ slice_cin;
                slice_cout = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
            end
            OP_NOR:  slice_out = ~(slice_a | slice_b);
            default: slice_out = slice_a;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Steps a shared 1-bit ALU slice over WIDTH-bit operands LSB first, between two valid/ready handshakes.
//   state   | meaning
//   IDLE    | ready for a new op, slice idle
//   RUN     | driving bit cnt into the slice, capturing result bit and carry
//   DONE    | result and flags valid, held until out_ready
module bit_serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [2:0]       slice_op,
    input  logic             slice_out,
    input  logic             slice_cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_c_q, flag_c_d, flag_v_q, flag_v_d, flag_z_q, flag_z_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= OP_AND;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flag_c_q <= flag_c_d;
            flag_v_q <= flag_v_d;
            flag_z_q <= flag_z_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        flag_c_d  = flag_c_q;
        flag_v_d  = flag_v_q;
        flag_z_d  = flag_z_q;
        in_ready  = 1'b0;
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_cin = 1'b0;
        slice_op  = 3'b000;

        case (state_q)
            ST_IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    state_d  = ST_RUN;
                    op_d     = op_e'(in_op);
                    a_d      = in_a;
                    b_d      = in_b;
                    cnt_d    = '0;
                    carry_d  = (op_e'(in_op) == OP_SUB);
                    result_d = '0;
                    flag_c_d = 1'b0;
                    flag_v_d = 1'b0;
                    flag_z_d = 1'b0;
                end
            end
            ST_RUN: begin
                slice_a   = a_q[cnt_q];
                slice_b   = b_q[cnt_q] ^ (op_q == OP_SUB);
                slice_cin = carry_q;
                slice_op  = slice_op_of(op_q);
                result_d[cnt_q] = slice_out;
                carry_d   = slice_cout;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    flag_c_d = is_arith(op_q) & slice_cout;
                    // Overflow: carry into the MSB differs from carry out of it.
                    flag_v_d = is_arith(op_q) & (carry_q ^ slice_cout);
                    flag_z_d = (result_d == '0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;
    assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed bench for bit_serial_alu_ctrl closed around a real 1-bit slice, WIDTH=8.
module tb_bit_serial_alu_ctrl;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       flag_c, flag_v, flag_z;
    logic       slice_a, slice_b, slice_cin;
    logic [2:0] slice_op;
    logic       slice_out, slice_cout;

    int n_checks = 0;
    int n_fail   = 0;

    bit_serial_alu_ctrl #(.WIDTH(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_c     (flag_c),
        .flag_v     (flag_v),
        .flag_z     (flag_z),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_op   (slice_op),
        .slice_out  (slice_out),
        .slice_cout (slice_cout)
    );

    alu_slice_1_bit u_slice (
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_op   (slice_op),
        .slice_out  (slice_out),
        .slice_cout (slice_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] r, output logic [2:0] cvz);
        logic [8:0] s;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = ~(a & b);
            3'd3: r = a ^ b;
            3'd4: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'd5: begin
                s = {1'b0, a} + {1'b0, ~b} + 9'd1;
                r = s[7:0];
                c = s[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            3'd6: r = ~(a | b);
            default: r = a;
        endcase
        cvz = {c, v, (r == 8'h00)};
    endfunction

    // Accepts one op, waits for out_valid (bounded) and leaves the result pending in DONE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic [2:0] cvz, output int lat, output logic [5:0] probe0);
        int guard;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        probe0 = {slice_a, slice_b, slice_cin, slice_op};
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        check({tag, "_out_valid"}, out_valid, 1);
        r   = result;
        cvz = {flag_c, flag_v, flag_z};
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_released"}, out_valid, 0);
    endtask

    logic [7:0] r;
    logic [2:0] cvz;
    logic [5:0] probe;
    int         lat;
    logic [2:0] ops [5];
    logic [7:0] as_ [5];
    logic [7:0] bs_ [5];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = 8'h00; in_b = 8'h00; out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 8'h00);
        check("rst_flags", {flag_c, flag_v, flag_z}, 3'b000);
        check("rst_slice", {slice_a, slice_b, slice_cin, slice_op}, 6'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);

        run_op("add7f", OP_ADD, 8'h7F, 8'h01, r, cvz, lat, probe);
        check("add7f_latency", lat, 8);
        check("add7f_slice_bit0", probe, 6'b110100);
        check("add7f_result", r, 8'h80);
        check("add7f_cvz", cvz, 3'b010);
        check("done_slice_idle", {slice_a, slice_b, slice_cin, slice_op}, 6'd0);
        check("done_in_ready", in_ready, 0);
        handshake("add7f");

        run_op("sub55", OP_SUB, 8'h05, 8'h05, r, cvz, lat, probe);
        check("sub55_slice_bit0", probe, 6'b101100);
        check("sub55_result", r, 8'h00);
        check("sub55_cvz", cvz, 3'b101);
        handshake("sub55");

        run_op("sub35", OP_SUB, 8'h03, 8'h05, r, cvz, lat, probe);
        check("sub35_result", r, 8'hFE);
        check("sub35_cvz", cvz, 3'b000);
        handshake("sub35");

        run_op("addff", OP_ADD, 8'hFF, 8'h01, r, cvz, lat, probe);
        check("addff_result", r, 8'h00);
        check("addff_cvz", cvz, 3'b101);
        handshake("addff");

        run_op("nand", OP_NAND, 8'hF0, 8'hCC, r, cvz, lat, probe);
        check("nand_result", r, 8'h3F);
        check("nand_cvz", cvz, 3'b000);
        handshake("nand");

        // Backpressure with a competing op pending on the input side.
        run_op("bp", OP_OR, 8'h12, 8'h40, r, cvz, lat, probe);
        check("bp_result", r, 8'h52);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = OP_XOR;
        in_a     = 8'hFF;
        in_b     = 8'h0F;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_result", result, 8'h52);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_released", out_valid, 0);
        check("bp_idle_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check("bp_second_not_taken", in_ready, 1);

        // Synchronous reset in the middle of an ADD at cnt=3.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_a     = 8'h11;
        in_b     = 8'h22;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready_high", in_ready, 1);
        run_op("xor", OP_XOR, 8'hAA, 8'hFF, r, cvz, lat, probe);
        check("xor_latency", lat, 8);
        check("xor_result", r, 8'h55);
        check("xor_cvz", cvz, 3'b000);
        handshake("xor");

        // Back-to-back stream with out_ready held high.
        begin
            int k, got, cyc, last_acc;
            logic [7:0] er;
            logic [2:0] ecvz;
            for (int i = 0; i < 5; i++) begin
                ops[i] = 3'($urandom_range(7, 0));
                as_[i] = 8'($urandom);
                bs_[i] = 8'($urandom);
            end
            out_ready = 1'b1;
            k = 0; got = 0; cyc = 0; last_acc = 0;
            while (got < 5 && cyc < 200) begin
                @(negedge clk);
                cyc++;
                if (out_valid) begin
                    ref_alu(ops[got], as_[got], bs_[got], er, ecvz);
                    check("b2b_result", result, er);
                    check("b2b_cvz", {flag_c, flag_v, flag_z}, ecvz);
                    got++;
                end
                if (in_ready && k < 5) begin
                    in_valid = 1'b1;
                    in_op    = ops[k];
                    in_a     = as_[k];
                    in_b     = bs_[k];
                    if (k > 0) check("b2b_spacing", cyc - last_acc, 10);
                    last_acc = cyc;
                    k++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            check("b2b_count", got, 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
